// File: rtl/main_memory_responder.sv
// -----------------------------------------------------------------------------
// main_memory_responder
//
// Word-addressed main memory that answers an L1 D-cache miss/store handshake.
// A load returns one full line (WORDS_PER_LINE words) starting at the
// line-aligned base of the requested address; every word is held until the
// cache acknowledges it by index. A store writes a single 32-bit word.
//
// Ports
//   CLK         in   clock, all state changes on the rising edge
//   RESET_N     in   asynchronous active-low reset
//   VALID       in   request from the cache, high for the whole transaction
//   LOAD        in   load qualifier (sampled when the request is accepted)
//   STORE       in   store qualifier (sampled when the request is accepted)
//   DATA_IN     in   address (with ACK_ADDR) or store data (with STORE_STB)
//   ACK_ADDR    in   strobe: DATA_IN carries the address
//   STORE_STB   in   strobe: DATA_IN carries the store data
//   WORD_ACK    in   index of the load word the cache has consumed
//   WORD_ACK_V  in   WORD_ACK qualifier
//   READY       out  responder engaged in a transaction
//   DATA_OUT    out  load word
//   ACK_DATA    out  index of the word on DATA_OUT
//   WORD_V      out  DATA_OUT / ACK_DATA valid
//   DONE        out  one-cycle completion pulse
// -----------------------------------------------------------------------------
module main_memory_responder #(
    parameter int WORDS_PER_LINE = 8,
    parameter int MEM_WORDS      = 1024,
    parameter int FIRST_WORD_LAT = 2
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        VALID,
    input  logic        LOAD,
    input  logic        STORE,
    input  logic [31:0] DATA_IN,
    input  logic        ACK_ADDR,
    input  logic        STORE_STB,
    input  logic [3:0]  WORD_ACK,
    input  logic        WORD_ACK_V,
    output logic        READY,
    output logic [31:0] DATA_OUT,
    output logic [3:0]  ACK_DATA,
    output logic        WORD_V,
    output logic        DONE
);

    localparam int AW = $clog2(MEM_WORDS);        // word index width
    localparam int IW = $clog2(WORDS_PER_LINE);   // word-in-line counter width
    localparam int LW = $clog2(FIRST_WORD_LAT + 2);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ADDR   = 3'd1,
        WAIT   = 3'd2,
        STREAM = 3'd3,
        STDATA = 3'd4,
        FINISH = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic            is_load_q, is_load_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [LW-1:0]   lat_q, lat_d;
    logic [IW-1:0]   i_q, i_d;
    logic            done_q;
    logic [31:0]     data_out_q;
    logic            wr_en;
    logic [AW-1:0]   rd_addr_d;
    logic [3:0]      i_ext;

    logic [31:0]     mem [0:MEM_WORDS-1];

    assign i_ext = 4'(i_q);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        is_load_d = is_load_q;
        idx_d     = idx_q;
        lat_d     = lat_q;
        i_d       = i_q;
        wr_en     = 1'b0;

        unique case (state_q)
            IDLE: begin
                lat_d = '0;
                i_d   = '0;
                // Ambiguous requests (both or neither qualifier) are refused.
                if (VALID && (LOAD ^ STORE)) begin
                    state_d   = ADDR;
                    is_load_d = LOAD;
                end
            end

            ADDR: begin
                if (!VALID) begin
                    state_d = IDLE;
                end else if (ACK_ADDR) begin
                    // Upper address bits are dropped so the address wraps.
                    idx_d = DATA_IN[AW+1:2];
                    lat_d = '0;
                    i_d   = '0;
                    if (!is_load_q)
                        state_d = STDATA;
                    else if (FIRST_WORD_LAT == 0)
                        state_d = STREAM;
                    else
                        state_d = WAIT;
                end
            end

            WAIT: begin
                if (!VALID) begin
                    state_d = IDLE;
                end else if (lat_q == LW'(FIRST_WORD_LAT - 1)) begin
                    state_d = STREAM;
                    i_d     = '0;
                end else begin
                    lat_d = lat_q + LW'(1);
                end
            end

            STREAM: begin
                if (!VALID) begin
                    state_d = IDLE;
                end else if (WORD_ACK_V && (WORD_ACK == i_ext)) begin
                    // Acks for any other index are stale and leave the word held.
                    if (i_q == IW'(WORDS_PER_LINE - 1))
                        state_d = FINISH;
                    else
                        i_d = i_q + IW'(1);
                end
            end

            STDATA: begin
                // The strobe wins over a simultaneous VALID drop: the data
                // was presented on this edge, so it is committed.
                if (STORE_STB) begin
                    wr_en   = 1'b1;
                    state_d = FINISH;
                end else if (!VALID) begin
                    state_d = IDLE;
                end
            end

            FINISH: begin
                if (!VALID)
                    state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    // Line base is the word index with its in-line bits replaced by the counter.
    assign rd_addr_d = {idx_d[AW-1:IW], i_d};

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= IDLE;
            is_load_q  <= 1'b0;
            idx_q      <= '0;
            lat_q      <= '0;
            i_q        <= '0;
            done_q     <= 1'b0;
            data_out_q <= '0;
        end else begin
            state_q   <= state_d;
            is_load_q <= is_load_d;
            idx_q     <= idx_d;
            lat_q     <= lat_d;
            i_q       <= i_d;
            done_q    <= (state_d == FINISH) && (state_q != FINISH);
            // Registered RAM read, addressed one cycle ahead so the word is
            // ready in the same cycle WORD_V rises or the index advances.
            if (state_d == STREAM)
                data_out_q <= mem[rd_addr_d];
        end
    end

    // Memory write port; contents are not touched by reset.
    always_ff @(posedge CLK) begin
        if (wr_en)
            mem[idx_q] <= DATA_IN;
    end

    assign READY    = (state_q != IDLE);
    assign WORD_V   = (state_q == STREAM);
    assign ACK_DATA = (state_q == STREAM) ? i_ext : 4'd0;
    assign DATA_OUT = data_out_q;
    assign DONE     = done_q;

endmodule

// File: tb/tb_main_memory_responder.sv
module tb_main_memory_responder;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        VALID, LOAD, STORE, ACK_ADDR, STORE_STB, WORD_ACK_V;
    logic [31:0] DATA_IN;
    logic [3:0]  WORD_ACK;
    logic        READY, WORD_V, DONE;
    logic [31:0] DATA_OUT;
    logic [3:0]  ACK_DATA;

    int n_vec = 0;
    int n_err = 0;

    typedef struct { logic [3:0] idx; logic [31:0] data; } exp_t;
    exp_t exp_q[$];

    logic [31:0] model_mem [0:1023];

    always #5 CLK = ~CLK;

    main_memory_responder #(
        .WORDS_PER_LINE(8), .MEM_WORDS(1024), .FIRST_WORD_LAT(2)
    ) dut (
        .CLK(CLK), .RESET_N(RESET_N), .VALID(VALID), .LOAD(LOAD), .STORE(STORE),
        .DATA_IN(DATA_IN), .ACK_ADDR(ACK_ADDR), .STORE_STB(STORE_STB),
        .WORD_ACK(WORD_ACK), .WORD_ACK_V(WORD_ACK_V), .READY(READY),
        .DATA_OUT(DATA_OUT), .ACK_DATA(ACK_DATA), .WORD_V(WORD_V), .DONE(DONE)
    );

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    task automatic do_store(input logic [31:0] addr, input logic [31:0] data);
        check("st_idle_ready", {31'd0, READY}, 32'd0);
        VALID = 1; STORE = 1; LOAD = 0;
        cyc();
        check("st_ready", {31'd0, READY}, 32'd1);
        DATA_IN = addr; ACK_ADDR = 1;
        cyc();
        ACK_ADDR = 0; DATA_IN = data; STORE_STB = 1;
        check("st_no_early_done", {31'd0, DONE}, 32'd0);
        cyc();
        model_mem[(addr >> 2) & 32'h3FF] = data;
        check("st_done", {31'd0, DONE}, 32'd1);
        STORE_STB = 0; VALID = 0; STORE = 0;
        cyc();
        check("st_done_once", {31'd0, DONE}, 32'd0);
        check("st_ready_drop", {31'd0, READY}, 32'd0);
        $display("store addr=0x%08h data=0x%08h", addr, data);
    endtask

    // late_word: index acked 5 cycles late with stale WORD_ACK=late_word-1
    // abort_word: VALID dropped when this word is presented
    task automatic do_load(input logic [31:0] addr, input int late_word, input int abort_word);
        int budget = 0;
        int zero_cnt = 0;
        int hold = 0;
        int late_obs = 0;
        bit fin = 0;
        bit seen = 0;
        bit aborted = 0;
        logic [9:0] base;
        base = 10'((addr >> 2) & 32'h3F8);
        VALID = 1; LOAD = 1; STORE = 0;
        cyc();
        check("ld_ready", {31'd0, READY}, 32'd1);
        DATA_IN = addr; ACK_ADDR = 1;
        cyc();
        ACK_ADDR = 0;
        for (int k = 0; k < 8; k++) begin
            exp_t e;
            e.idx  = 4'(k);
            e.data = model_mem[base + 10'(k)];
            exp_q.push_back(e);
        end
        while (!fin && budget < 200) begin
            budget++;
            if (DONE) begin
                check("ld_all_words", exp_q.size(), 0);
                check("ld_wv_at_done", {31'd0, WORD_V}, 32'd0);
                WORD_ACK_V = 0;
                fin = 1;
            end else if (WORD_V) begin
                seen = 1;
                if (exp_q.size() == 0) begin
                    check("ld_extra_word", {31'd0, WORD_V}, 32'd0);
                    WORD_ACK_V = 0;
                end else begin
                    check("ld_index", {28'd0, ACK_DATA}, {28'd0, exp_q[0].idx});
                    check("ld_data", DATA_OUT, exp_q[0].data);
                    if (int'(ACK_DATA) == late_word) late_obs++;
                    if (int'(exp_q[0].idx) == abort_word) begin
                        VALID = 0; LOAD = 0; WORD_ACK_V = 0;
                        cyc();
                        check("ab_ready", {31'd0, READY}, 32'd0);
                        check("ab_wv", {31'd0, WORD_V}, 32'd0);
                        check("ab_done", {31'd0, DONE}, 32'd0);
                        exp_q.delete();
                        fin = 1;
                        aborted = 1;
                    end else if (int'(exp_q[0].idx) == late_word && hold < 5) begin
                        hold++;
                        WORD_ACK_V = 1;
                        WORD_ACK = 4'(late_word - 1);
                    end else begin
                        WORD_ACK_V = 1;
                        WORD_ACK = exp_q[0].idx;
                        void'(exp_q.pop_front());
                    end
                end
            end else begin
                if (!seen) zero_cnt++;
                WORD_ACK_V = 0;
            end
            if (!fin) cyc();
        end
        check("ld_finished", {31'd0, fin}, 32'd1);
        check("ld_latency", zero_cnt, 2);
        if (late_word >= 0) check("ld_late_held", late_obs, 6);
        if (!aborted) begin
            VALID = 0; LOAD = 0; WORD_ACK_V = 0;
            cyc();
            check("ld_done_once", {31'd0, DONE}, 32'd0);
            check("ld_ready_drop", {31'd0, READY}, 32'd0);
        end else begin
            cyc();
            check("ab_no_late_done", {31'd0, DONE}, 32'd0);
        end
        exp_q.delete();
        $display("load addr=0x%08h late=%0d abort=%0d", addr, late_word, abort_word);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET_N = 0; VALID = 0; LOAD = 0; STORE = 0; DATA_IN = '0;
        ACK_ADDR = 0; STORE_STB = 0; WORD_ACK = '0; WORD_ACK_V = 0;
        cyc(); cyc();
        check("rst_ready", {31'd0, READY}, 32'd0);
        check("rst_wv", {31'd0, WORD_V}, 32'd0);
        check("rst_done", {31'd0, DONE}, 32'd0);
        check("rst_data", DATA_OUT, 32'd0);
        check("rst_ackd", {28'd0, ACK_DATA}, 32'd0);
        RESET_N = 1;
        cyc();

        for (int w = 16; w < 24; w++)
            do_store(32'(w) << 2, 32'h100 + 32'(w));
        do_load(32'h0000_0044, -1, -1);         // 0x110..0x117

        do_store(32'h0000_0044, 32'hDEAD_BEEF);  // word 17
        do_load(32'h0000_0040, -1, -1);          // load right after store sees new data

        do_store(32'h0000_1044, 32'hCAFE_F00D);  // wraps onto word 17
        do_load(32'h0000_005C, 3, -1);           // word 3 late with stale ack 2

        do_load(32'h0000_0044, -1, 4);           // abort at word 4
        do_load(32'h0000_0044, -1, -1);          // next load completes

        // Reset in STDATA before the strobe: no write, outputs cleared at once.
        VALID = 1; STORE = 1;
        cyc();
        DATA_IN = 32'h0000_0050; ACK_ADDR = 1;
        cyc();
        ACK_ADDR = 0; DATA_IN = 32'hBAD0_BAD0;
        #3 RESET_N = 0;
        #1;
        check("mid_rst_ready", {31'd0, READY}, 32'd0);
        check("mid_rst_wv", {31'd0, WORD_V}, 32'd0);
        check("mid_rst_done", {31'd0, DONE}, 32'd0);
        check("mid_rst_data", DATA_OUT, 32'd0);
        VALID = 0; STORE = 0;
        cyc();
        RESET_N = 1;
        cyc();
        $display("reset during store data phase");
        do_load(32'h0000_0040, -1, -1);          // word 20 keeps its old value

        // Both qualifiers high: refused.
        VALID = 1; LOAD = 1; STORE = 1;
        for (int k = 0; k < 4; k++) begin
            cyc();
            check("both_qual_ready", {31'd0, READY}, 32'd0);
        end
        VALID = 0; LOAD = 0; STORE = 0;
        cyc();
        $display("ambiguous request refused");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
